// File: rtl/registro_arranque_multicanal_pkg.sv
// Shared encodings for the multichannel start-register bank: channel FSM states
// and the command bytes accepted on a channel write.
package arranque_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } canal_estado_t;

    localparam logic [7:0] CMD_START = 8'h01;
    localparam logic [7:0] CMD_STOP  = 8'h00;

endpackage

// File: rtl/registro_arranque_multicanal_if.sv
// Processor output/input port bus seen by the start-register bank.
// The processor side is the master; the register bank is the slave.
interface registro_arranque_multicanal_if;

    logic [7:0] port_id;
    logic [7:0] port_out;
    logic [7:0] port_in;
    logic       W_Strobe;
    logic       R_Strobe;

    modport master (
        output port_id,
        output port_out,
        output W_Strobe,
        output R_Strobe,
        input  port_in
    );

    modport slave (
        input  port_id,
        input  port_out,
        input  W_Strobe,
        input  R_Strobe,
        output port_in
    );

endinterface

// File: rtl/registro_arranque_multicanal_canal.sv
// One start channel: IDLE/RUN FSM, sticky done flag and, when ARRANQUE_TIMEOUT_EN
// is defined, a RUN-cycle counter with a sticky timeout flag.
module arranque_canal #(
    parameter int TIMEOUT_W   = 16,
    parameter int TIMEOUT_MAX = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_wr,
    input  logic [7:0] i_data,
    input  logic       i_listo,
    input  logic       i_clr,
    output logic       o_run,
    output logic       o_done,
    output logic       o_tout
);

    import arranque_pkg::*;

    canal_estado_t r_estado;
    canal_estado_t w_estado_sig;
    logic          w_fin_listo;
    logic          w_fin_tout;
    logic          w_timeout;
    logic          r_done;

    if (TIMEOUT_MAX < 2 || TIMEOUT_MAX > (2 ** TIMEOUT_W) - 1) begin : g_param_err
        $error("arranque_canal: TIMEOUT_MAX out of range for TIMEOUT_W");
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado <= ST_IDLE;
        end else begin
            r_estado <= w_estado_sig;
        end
    end

    // listo wins over timeout, timeout wins over an abort write
    always_comb begin
        w_estado_sig = r_estado;
        w_fin_listo  = 1'b0;
        w_fin_tout   = 1'b0;
        case (r_estado)
            ST_IDLE: begin
                if (i_wr && i_data == CMD_START) begin
                    w_estado_sig = ST_RUN;
                end
            end
            ST_RUN: begin
                if (i_listo) begin
                    w_estado_sig = ST_IDLE;
                    w_fin_listo  = 1'b1;
                end else if (w_timeout) begin
                    w_estado_sig = ST_IDLE;
                    w_fin_tout   = 1'b1;
                end else if (i_wr && i_data == CMD_STOP) begin
                    w_estado_sig = ST_IDLE;
                end
            end
            default: begin
                w_estado_sig = ST_IDLE;
            end
        endcase
    end

    // a new completion on the same edge as a status read survives the clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done <= 1'b0;
        end else if (w_fin_listo) begin
            r_done <= 1'b1;
        end else if (i_clr) begin
            r_done <= 1'b0;
        end
    end

`ifdef ARRANQUE_TIMEOUT_EN
    localparam logic [TIMEOUT_W-1:0] LP_ULTIMO = TIMEOUT_W'(TIMEOUT_MAX - 1);

    logic [TIMEOUT_W-1:0] r_cuenta;
    logic                 r_tout;

    // held at zero while idle, so every start begins counting from 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cuenta <= '0;
        end else if (r_estado == ST_IDLE || w_estado_sig == ST_IDLE) begin
            r_cuenta <= '0;
        end else begin
            r_cuenta <= r_cuenta + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tout <= 1'b0;
        end else if (w_fin_tout) begin
            r_tout <= 1'b1;
        end else if (i_clr) begin
            r_tout <= 1'b0;
        end
    end

    assign w_timeout = (r_cuenta == LP_ULTIMO);
    assign o_tout    = r_tout;
`else
    assign w_timeout = 1'b0;
    assign o_tout    = 1'b0;
`endif

    assign o_run  = (r_estado == ST_RUN);
    assign o_done = r_done;

endmodule

// File: rtl/registro_arranque_multicanal.sv
// Bank of N_CH start registers on the 8-bit port bus, with clear-on-read status
// and interrupt. Optional per-channel timeout enabled by ARRANQUE_TIMEOUT_EN.
module registro_arranque_multicanal #(
    parameter int         N_CH        = 4,
    parameter logic [7:0] BASE_ID     = 8'h10,
    parameter logic [7:0] STATUS_ID   = 8'h1F,
    parameter int         TIMEOUT_W   = 16,
    parameter int         TIMEOUT_MAX = 50000
) (
    input  logic                           clk,
    input  logic                           rst_n,
    registro_arranque_multicanal_if.slave  bus,
    input  logic [N_CH-1:0]                listo,
    output logic [N_CH-1:0]                dato_salida,
    output logic                           busy,
    output logic                           irq
);

    import arranque_pkg::*;

    logic [N_CH-1:0] w_wr;
    logic [N_CH-1:0] w_done;
    logic [N_CH-1:0] w_tout;
    logic [3:0]      w_done4;
    logic [3:0]      w_tout4;
    logic            w_clr;
    logic            r_irq;

    if (N_CH < 1 || N_CH > 4) begin : g_nch_err
        $error("registro_arranque_multicanal: N_CH must be 1..4");
    end
    if (STATUS_ID >= BASE_ID && 32'(STATUS_ID) < 32'(BASE_ID) + N_CH) begin : g_id_err
        $error("registro_arranque_multicanal: STATUS_ID overlaps channel ports");
    end

    assign w_clr = bus.R_Strobe && (bus.port_id == STATUS_ID);

    for (genvar g = 0; g < N_CH; g++) begin : g_canal
        localparam logic [7:0] LP_ID = 8'(BASE_ID + g);

        assign w_wr[g] = bus.W_Strobe && (bus.port_id == LP_ID);

        arranque_canal #(
            .TIMEOUT_W   (TIMEOUT_W),
            .TIMEOUT_MAX (TIMEOUT_MAX)
        ) u_canal (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_wr    (w_wr[g]),
            .i_data  (bus.port_out),
            .i_listo (listo[g]),
            .i_clr   (w_clr),
            .o_run   (dato_salida[g]),
            .o_done  (w_done[g]),
            .o_tout  (w_tout[g])
        );
    end

    always_comb begin
        w_done4             = '0;
        w_tout4             = '0;
        w_done4[N_CH-1:0]   = w_done;
        w_tout4[N_CH-1:0]   = w_tout;
    end

    // read mux shows pre-clear flags during the clearing cycle
    always_comb begin
        bus.port_in = 8'h00;
        if (bus.port_id == STATUS_ID) begin
            bus.port_in = {w_tout4, w_done4};
        end
        for (int i = 0; i < N_CH; i++) begin
            if (bus.port_id == 8'(BASE_ID + i)) begin
                bus.port_in = {7'b0, dato_salida[i]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= |{w_done, w_tout};
        end
    end

    assign busy = |dato_salida;
    assign irq  = r_irq;

endmodule

// File: tb/tb_registro_arranque_multicanal.sv
// Directed bench for registro_arranque_multicanal: vector table plus sequences
// for timeout, restart-while-running and asynchronous reset.
module tb_registro_arranque_multicanal;

    localparam int NV = 20;

    typedef struct {
        logic [7:0] pid;
        logic [7:0] pdata;
        logic       w;
        logic       r;
        logic [3:0] listo;
        logic [7:0] expPin;
        logic [3:0] expDato;
        logic       expBusy;
        logic       expIrq;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] listo;
    logic [3:0] datoSalida;
    logic       busy;
    logic       irq;
    int         nPass;
    int         nChecks;
    vec_t       vecs [NV];

    registro_arranque_multicanal_if bus ();

    registro_arranque_multicanal #(
        .N_CH        (4),
        .BASE_ID     (8'h10),
        .STATUS_ID   (8'h1F),
        .TIMEOUT_W   (16),
        .TIMEOUT_MAX (10)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .listo       (listo),
        .dato_salida (datoSalida),
        .busy        (busy),
        .irq         (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        nChecks++;
        if (act === exp) begin
            nPass++;
        end else begin
            $display("[TB] FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] pid, input logic [7:0] pdata,
                                 input logic w, input logic r, input logic [3:0] l);
        bus.port_id  = pid;
        bus.port_out = pdata;
        bus.W_Strobe = w;
        bus.R_Strobe = r;
        listo        = l;
    endtask

    task automatic idleBus;
        applyStimulus(8'h00, 8'h00, 1'b0, 1'b0, 4'b0000);
    endtask

    initial begin
        int cyc;
        nPass   = 0;
        nChecks = 0;

        vecs[0]  = '{8'h00, 8'h00, 1'b0, 1'b0, 4'b0000, 8'h00, 4'b0000, 1'b0, 1'b0};
        vecs[1]  = '{8'h12, 8'h01, 1'b1, 1'b0, 4'b0000, 8'h00, 4'b0100, 1'b1, 1'b0};
        vecs[2]  = '{8'h12, 8'h00, 1'b0, 1'b0, 4'b0100, 8'h01, 4'b0000, 1'b0, 1'b0};
        vecs[3]  = '{8'h1F, 8'h00, 1'b0, 1'b1, 4'b0000, 8'h04, 4'b0000, 1'b0, 1'b1};
        vecs[4]  = '{8'h1F, 8'h00, 1'b0, 1'b1, 4'b0000, 8'h00, 4'b0000, 1'b0, 1'b0};
        vecs[5]  = '{8'h10, 8'h01, 1'b1, 1'b0, 4'b0000, 8'h00, 4'b0001, 1'b1, 1'b0};
        vecs[6]  = '{8'h11, 8'h05, 1'b1, 1'b0, 4'b0000, 8'h00, 4'b0001, 1'b1, 1'b0};
        vecs[7]  = '{8'h10, 8'h01, 1'b1, 1'b0, 4'b0000, 8'h01, 4'b0001, 1'b1, 1'b0};
        vecs[8]  = '{8'h10, 8'h00, 1'b1, 1'b0, 4'b0000, 8'h01, 4'b0000, 1'b0, 1'b0};
        vecs[9]  = '{8'h1F, 8'h00, 1'b0, 1'b1, 4'b0000, 8'h00, 4'b0000, 1'b0, 1'b0};
        vecs[10] = '{8'h11, 8'h01, 1'b1, 1'b0, 4'b0000, 8'h00, 4'b0010, 1'b1, 1'b0};
        vecs[11] = '{8'h11, 8'h00, 1'b1, 1'b0, 4'b0010, 8'h01, 4'b0000, 1'b0, 1'b0};
        vecs[12] = '{8'h1F, 8'h00, 1'b0, 1'b0, 4'b0000, 8'h02, 4'b0000, 1'b0, 1'b1};
        vecs[13] = '{8'h10, 8'h01, 1'b1, 1'b0, 4'b0000, 8'h00, 4'b0001, 1'b1, 1'b1};
        vecs[14] = '{8'h1F, 8'h00, 1'b0, 1'b1, 4'b0001, 8'h02, 4'b0000, 1'b0, 1'b1};
        vecs[15] = '{8'h1F, 8'h00, 1'b0, 1'b1, 4'b0000, 8'h01, 4'b0000, 1'b0, 1'b1};
        vecs[16] = '{8'h1F, 8'h00, 1'b0, 1'b0, 4'b0000, 8'h00, 4'b0000, 1'b0, 1'b0};
        vecs[17] = '{8'h1F, 8'h00, 1'b0, 1'b0, 4'b1111, 8'h00, 4'b0000, 1'b0, 1'b0};
        vecs[18] = '{8'h1F, 8'h00, 1'b0, 1'b0, 4'b0000, 8'h00, 4'b0000, 1'b0, 1'b0};
        vecs[19] = '{8'h20, 8'h00, 1'b0, 1'b0, 4'b0000, 8'h00, 4'b0000, 1'b0, 1'b0};

        rst_n = 1'b0;
        idleBus();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < NV; i++) begin
            applyStimulus(vecs[i].pid, vecs[i].pdata, vecs[i].w, vecs[i].r, vecs[i].listo);
            #1;
            checkOutput($sformatf("v%0d port_in", i), bus.port_in, vecs[i].expPin);
            tick();
            checkOutput($sformatf("v%0d dato_salida", i), {4'h0, datoSalida}, {4'h0, vecs[i].expDato});
            checkOutput($sformatf("v%0d busy", i), {7'b0, busy}, {7'b0, vecs[i].expBusy});
            checkOutput($sformatf("v%0d irq", i), {7'b0, irq}, {7'b0, vecs[i].expIrq});
        end
        idleBus();

        // channel 3 started with no listo
        applyStimulus(8'h13, 8'h01, 1'b1, 1'b0, 4'b0000);
        tick();
        idleBus();
        cyc = 0;
        while (datoSalida[3] && cyc < 30) begin
            cyc++;
            tick();
        end
`ifdef ARRANQUE_TIMEOUT_EN
        checkOutput("timeout high cycles", 8'(cyc), 8'd10);
        applyStimulus(8'h1F, 8'h00, 1'b0, 1'b1, 4'b0000);
        #1;
        checkOutput("timeout status", bus.port_in, 8'h80);
        tick();
        checkOutput("timeout irq", {7'b0, irq}, 8'h01);
        #1;
        checkOutput("timeout status cleared", bus.port_in, 8'h00);
        idleBus();
        tick();

        // restart command while running at count 5 must not extend the run
        applyStimulus(8'h13, 8'h01, 1'b1, 1'b0, 4'b0000);
        tick();
        idleBus();
        cyc = 0;
        while (datoSalida[3] && cyc < 30) begin
            if (cyc == 5) begin
                applyStimulus(8'h13, 8'h01, 1'b1, 1'b0, 4'b0000);
            end else begin
                idleBus();
            end
            cyc++;
            tick();
        end
        idleBus();
        checkOutput("restart ignored high cycles", 8'(cyc), 8'd10);
        applyStimulus(8'h1F, 8'h00, 1'b0, 1'b1, 4'b0000);
        tick();
        idleBus();
`else
        checkOutput("no timeout still running", {7'b0, datoSalida[3]}, 8'h01);
        checkOutput("no timeout cycles", 8'(cyc), 8'd30);
        applyStimulus(8'h1F, 8'h00, 1'b0, 1'b0, 4'b0000);
        #1;
        checkOutput("no timeout status", bus.port_in, 8'h00);
        applyStimulus(8'h13, 8'h01, 1'b1, 1'b0, 4'b0000);
        tick();
        checkOutput("restart keeps running", {7'b0, datoSalida[3]}, 8'h01);
        applyStimulus(8'h13, 8'h00, 1'b1, 1'b0, 4'b0000);
        tick();
        idleBus();
        checkOutput("abort ch3", {4'h0, datoSalida}, 8'h00);
`endif

        // start all channels then reset asynchronously between edges
        for (int c = 0; c < 4; c++) begin
            applyStimulus(8'(8'h10 + c), 8'h01, 1'b1, 1'b0, 4'b0000);
            tick();
        end
        idleBus();
        checkOutput("all running", {4'h0, datoSalida}, 8'h0F);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async reset dato_salida", {4'h0, datoSalida}, 8'h00);
        checkOutput("async reset busy", {7'b0, busy}, 8'h00);
        checkOutput("async reset irq", {7'b0, irq}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        applyStimulus(8'h10, 8'h00, 1'b0, 1'b0, 4'b0000);
        #1;
        checkOutput("post reset port 10", bus.port_in, 8'h00);
        applyStimulus(8'h1F, 8'h00, 1'b0, 1'b0, 4'b0000);
        #1;
        checkOutput("post reset status", bus.port_in, 8'h00);
        idleBus();
        tick();

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
